fas: RTL and testbench

- Parameterised full adder/subtractor (WIDTH bits, default 1) with registered outputs.
- Add: {cout,s} = a + b + cin.
- Subtract: {cout,s} = a + ~b + cin. Two's-complement subtract needs cin=1 at the LSB; cout=1 means "no borrow".
- Leaf arithmetic block, chainable through cin/cout; a datapath ALU uses it for add/sub.

---
 rtl/fas_pkg.sv | 8 +
 rtl/fas_cell.sv | 20 ++
 rtl/fas.sv | 58 +++++
 tb/tb_fas.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared constants for the fas adder/subtractor and its bit cell.
package fas_pkg;

    localparam logic FAS_OP_ADD        = 1'b0;
    localparam logic FAS_OP_SUB        = 1'b1;
    localparam int   FAS_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/fas_cell.sv
// 1-bit full adder/subtractor cell, purely combinational (0 cycles, no flow control).
// The subtract select only inverts b; the carry-in is always the caller's.
module fas_cell
    import fas_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic s_op,
    output logic s,
    output logic cout
);

    logic bx;

    assign bx   = (s_op == FAS_OP_SUB) ? ~b : b;
    assign s    = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);

endmodule

// File: rtl/fas.sv
// WIDTH-bit ripple adder/subtractor with registered outputs: 1-cycle latency, one op accepted every cycle, no backpressure.
// Optional signed-overflow output ovf enabled by FAS_OVERFLOW_EN.
module fas
    import fas_pkg::*;
#(
    parameter int WIDTH = FAS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             s_op,
    output logic [WIDTH-1:0] s,
`ifdef FAS_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             cout
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fas_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s_op (s_op),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum;
            cout <= c[WIDTH];
        end
    end

`ifdef FAS_OVERFLOW_EN
    // Carries into and out of the MSB differ exactly on signed overflow; for WIDTH=1 c[0] is cin.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_fas.sv
// Directed self-checking bench for fas at WIDTH=1 and WIDTH=8 (ovf checks when FAS_OVERFLOW_EN is defined).
module tb_fas;
    import fas_pkg::*;

    logic       clk;
    logic       rst;
    logic       a1, b1, cin1, op1;
    logic       s1, cout1;
    logic [7:0] a8, b8;
    logic       cin8, op8;
    logic [7:0] s8;
    logic       cout8;
`ifdef FAS_OVERFLOW_EN
    logic       ovf1, ovf8;
`endif

    int checks   = 0;
    int failures = 0;

    fas #(.WIDTH(1)) u_w1 (
        .clk  (clk),
        .rst  (rst),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
        .s_op (op1),
        .s    (s1),
`ifdef FAS_OVERFLOW_EN
        .ovf  (ovf1),
`endif
        .cout (cout1)
    );

    fas #(.WIDTH(8)) u_w8 (
        .clk  (clk),
        .rst  (rst),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .s_op (op8),
        .s    (s8),
`ifdef FAS_OVERFLOW_EN
        .ovf  (ovf8),
`endif
        .cout (cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp1;
        logic       pcin;
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; op1 = FAS_OP_ADD;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; op8 = FAS_OP_ADD;

        step();
        chk("reset_w1", {7'd0, cout1, s1}, 9'h000);
        chk("reset_w8", {cout8, s8}, 9'h000);
`ifdef FAS_OVERFLOW_EN
        chk("reset_ovf", {7'd0, ovf1, ovf8}, 9'h000);
`endif

        // 1+1 add; 8-bit 5-7 with borrow
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; op1 = FAS_OP_ADD;
        a8 = 8'h05; b8 = 8'h07; cin8 = 1'b1; op8 = FAS_OP_SUB;
        step();
        chk("w1_add_1p1", {7'd0, cout1, s1}, 9'h002);
        chk("w8_sub_5m7", {cout8, s8}, 9'h0FE);
`ifdef FAS_OVERFLOW_EN
        chk("w8_sub_5m7_ovf", {8'd0, ovf8}, 9'h000);
`endif

        // 1-1 sub; 8-bit 0x80-1 signed overflow
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; op1 = FAS_OP_SUB;
        a8 = 8'h80; b8 = 8'h01; cin8 = 1'b1; op8 = FAS_OP_SUB;
        step();
        chk("w1_sub_1m1", {7'd0, cout1, s1}, 9'h002);
        chk("w8_sub_80m1", {cout8, s8}, 9'h17F);
`ifdef FAS_OVERFLOW_EN
        chk("w8_sub_80m1_ovf", {8'd0, ovf8}, 9'h001);
`endif

        // 1+1+1 add; 8-bit 0xFF+1 wrap
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; op1 = FAS_OP_ADD;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; op8 = FAS_OP_ADD;
        step();
        chk("w1_add_1p1p1", {7'd0, cout1, s1}, 9'h003);
        chk("w8_add_wrap", {cout8, s8}, 9'h100);
`ifdef FAS_OVERFLOW_EN
        chk("w8_add_wrap_ovf", {8'd0, ovf8}, 9'h000);
`endif

        // 8-bit 0x7F+1 signed overflow
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; op8 = FAS_OP_ADD;
        step();
        chk("w8_add_7fp1", {cout8, s8}, 9'h080);
`ifdef FAS_OVERFLOW_EN
        chk("w8_add_7fp1_ovf", {8'd0, ovf8}, 9'h001);
`endif

        // Exhaustive WIDTH=1, new inputs every cycle, each result checked one edge later
        exp1 = 2'b00;
        pcin = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                chk($sformatf("w1_exh_%0d", k - 1), {7'd0, cout1, s1}, {7'd0, exp1});
`ifdef FAS_OVERFLOW_EN
                chk($sformatf("w1_exh_ovf_%0d", k - 1), {8'd0, ovf1}, {8'd0, exp1[1] ^ pcin});
`endif
            end
            if (k < 16) begin
                logic [3:0] v;
                v = 4'(k);
                a1 = v[3]; b1 = v[2]; cin1 = v[1]; op1 = v[0];
                exp1 = {1'b0, v[3]} + {1'b0, v[2] ^ v[0]} + {1'b0, v[1]};
                pcin = v[1];
                step();
            end
        end

        // Reset mid-stream discards in-flight work
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; op1 = FAS_OP_ADD;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; op8 = FAS_OP_ADD;
        step();
        chk("pre_rst_w1", {7'd0, cout1, s1}, 9'h001);
        chk("pre_rst_w8", {cout8, s8}, 9'h046);

        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; op1 = FAS_OP_ADD;
        a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1; op8 = FAS_OP_ADD;
        step();
        chk("mid_rst_w1", {7'd0, cout1, s1}, 9'h000);
        chk("mid_rst_w8", {cout8, s8}, 9'h000);
`ifdef FAS_OVERFLOW_EN
        chk("mid_rst_ovf", {7'd0, ovf1, ovf8}, 9'h000);
`endif

        rst = 1'b0;
        a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; op1 = FAS_OP_ADD;
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; op8 = FAS_OP_ADD;
        step();
        chk("post_rst_w1", {7'd0, cout1, s1}, 9'h001);
        chk("post_rst_w8", {cout8, s8}, 9'h007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
